// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - shared states, mode codes and lamp patterns for the lamp sequencer
package lamp_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_HAZ  = 3'd7
  } state_t;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RIGHT = 2'd2;
  localparam logic [1:0] MODE_HAZ   = 2'd3;

  localparam logic [2:0] LAMP_OFF  = 3'b000;
  localparam logic [2:0] LAMP_ONE  = 3'b001;
  localparam logic [2:0] LAMP_TWO  = 3'b011;
  localparam logic [2:0] LAMP_FULL = 3'b111;

  // Background pattern for a side the active sweep is not using.
  function automatic logic [2:0] idle_side(input logic brake_q);
    return brake_q ? LAMP_FULL : LAMP_OFF;
  endfunction

endpackage

// File: rtl/lamp_prescaler.sv
// rtl/lamp_prescaler.sv - free-running step prescaler, tick on the last count
module lamp_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || count == LAST) count <= '0;
    else                      count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/lamp_sequencer.sv
// rtl/lamp_sequencer.sv - turn/hazard lamp sweep FSM with brake overlay
module lamp_sequencer
  import lamp_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turn_left,
  input  logic       turn_right,
  input  logic       emergency,
  input  logic       brake,
  output logic [2:0] left_lamp,
  output logic [2:0] right_lamp,
  output logic [1:0] mode,
  output logic       busy
);

  state_t state;
  logic   brake_q;
  logic   tick;

  lamp_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      brake_q <= 1'b0;
    end else begin
      brake_q <= brake;
      if (tick) begin
        case (state)
          S_IDLE: begin
            if (emergency || (turn_left && turn_right)) state <= S_HAZ;
            else if (turn_left)                         state <= S_L1;
            else if (turn_right)                        state <= S_R1;
            else                                        state <= S_IDLE;
          end
          // Emergency preempts any sweep step in progress.
          S_L1:    state <= emergency ? S_HAZ : S_L2;
          S_L2:    state <= emergency ? S_HAZ : S_L3;
          S_L3:    state <= emergency ? S_HAZ : S_IDLE;
          S_R1:    state <= emergency ? S_HAZ : S_R2;
          S_R2:    state <= emergency ? S_HAZ : S_R3;
          S_R3:    state <= emergency ? S_HAZ : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    left_lamp  = idle_side(brake_q);
    right_lamp = idle_side(brake_q);
    mode       = MODE_IDLE;
    case (state)
      S_L1:  begin left_lamp  = LAMP_ONE;  mode = MODE_LEFT;  end
      S_L2:  begin left_lamp  = LAMP_TWO;  mode = MODE_LEFT;  end
      S_L3:  begin left_lamp  = LAMP_FULL; mode = MODE_LEFT;  end
      S_R1:  begin right_lamp = LAMP_ONE;  mode = MODE_RIGHT; end
      S_R2:  begin right_lamp = LAMP_TWO;  mode = MODE_RIGHT; end
      S_R3:  begin right_lamp = LAMP_FULL; mode = MODE_RIGHT; end
      S_HAZ: begin
        left_lamp  = LAMP_FULL;
        right_lamp = LAMP_FULL;
        mode       = MODE_HAZ;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_lamp_sequencer.sv
// tb/tb_lamp_sequencer.sv - scoreboard bench for lamp_sequencer with TICK_DIV=4
module tb_lamp_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       turn_left = 1'b0;
  logic       turn_right = 1'b0;
  logic       emergency = 1'b0;
  logic       brake = 1'b0;
  logic [2:0] left_lamp;
  logic [2:0] right_lamp;
  logic [1:0] mode;
  logic       busy;

  typedef struct {
    logic [2:0] l;
    logic [2:0] r;
    logic [1:0] m;
    logic       b;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   scen = 0;
  int   step = 0;
  bit   done = 1'b0;

  lamp_sequencer #(.TICK_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .turn_left  (turn_left),
    .turn_right (turn_right),
    .emergency  (emergency),
    .brake      (brake),
    .left_lamp  (left_lamp),
    .right_lamp (right_lamp),
    .mode       (mode),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Apply inputs for the next n edges; expected outputs hold after each of those edges.
  task automatic drv(input int n, input logic r, input logic tl, input logic tr,
                     input logic em, input logic br, input logic [2:0] el,
                     input logic [2:0] er, input logic [1:0] m, input logic b);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      rst = r; turn_left = tl; turn_right = tr; emergency = em; brake = br;
      e.l = el; e.r = er; e.m = m; e.b = b; e.tag = scen * 1000 + step;
      exp_q.push_back(e);
      step++;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input int s);
    scen = s;
    step = 0;
    drv(1, 1, 0, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (left_lamp !== e.l || right_lamp !== e.r || mode !== e.m || busy !== e.b) begin
          errors++;
          $display("FAIL outputs tag=%0d got l=%b r=%b mode=%0d busy=%b want l=%b r=%b mode=%0d busy=%b",
                   e.tag, left_lamp, right_lamp, mode, busy, e.l, e.r, e.m, e.b);
        end
      end
    end
  end

  initial begin : stimulus
    // Held left: full sweep, dark tick, second sweep, release mid-sweep completes.
    do_reset(1);
    drv(3, 0, 1, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(4, 0, 1, 0, 0, 0, 3'b001, 3'b000, 2'd1, 1'b1);
    drv(4, 0, 1, 0, 0, 0, 3'b011, 3'b000, 2'd1, 1'b1);
    drv(4, 0, 1, 0, 0, 0, 3'b111, 3'b000, 2'd1, 1'b1);
    drv(4, 0, 1, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(1, 0, 1, 0, 0, 0, 3'b001, 3'b000, 2'd1, 1'b1);
    drv(3, 0, 0, 0, 0, 0, 3'b001, 3'b000, 2'd1, 1'b1);
    drv(4, 0, 0, 0, 0, 0, 3'b011, 3'b000, 2'd1, 1'b1);
    drv(4, 0, 0, 0, 0, 0, 3'b111, 3'b000, 2'd1, 1'b1);
    drv(8, 0, 0, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);

    // Both turns -> hazard flashing, then reset while in hazard.
    do_reset(2);
    drv(3, 0, 1, 1, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(4, 0, 1, 1, 0, 0, 3'b111, 3'b111, 2'd3, 1'b1);
    drv(4, 0, 1, 1, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(4, 0, 1, 1, 0, 0, 3'b111, 3'b111, 2'd3, 1'b1);

    // Right sweep preempted by emergency at R2.
    do_reset(3);
    drv(3, 0, 0, 1, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(4, 0, 0, 1, 0, 0, 3'b000, 3'b001, 2'd2, 1'b1);
    drv(1, 0, 0, 0, 0, 0, 3'b000, 3'b011, 2'd2, 1'b1);
    drv(2, 0, 0, 0, 0, 0, 3'b000, 3'b011, 2'd2, 1'b1);
    drv(1, 0, 0, 0, 1, 0, 3'b000, 3'b011, 2'd2, 1'b1);
    drv(1, 0, 0, 0, 1, 0, 3'b111, 3'b111, 2'd3, 1'b1);
    drv(3, 0, 0, 0, 0, 0, 3'b111, 3'b111, 2'd3, 1'b1);
    drv(4, 0, 0, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);

    // Brake while idle, then brake overlay during a left sweep.
    do_reset(4);
    drv(1, 0, 0, 0, 0, 1, 3'b111, 3'b111, 2'd0, 1'b0);
    drv(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(1, 0, 1, 0, 0, 1, 3'b111, 3'b111, 2'd0, 1'b0);
    drv(1, 0, 1, 0, 0, 1, 3'b001, 3'b111, 2'd1, 1'b1);
    drv(3, 0, 0, 0, 0, 1, 3'b001, 3'b111, 2'd1, 1'b1);
    drv(4, 0, 0, 0, 0, 1, 3'b011, 3'b111, 2'd1, 1'b1);
    drv(4, 0, 0, 0, 0, 1, 3'b111, 3'b111, 2'd1, 1'b1);
    drv(1, 0, 0, 0, 0, 1, 3'b111, 3'b111, 2'd0, 1'b0);
    drv(1, 0, 0, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);

    // Reset during L2 aborts; next tick four edges after the reset edge.
    do_reset(5);
    drv(3, 0, 1, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(4, 0, 1, 0, 0, 0, 3'b001, 3'b000, 2'd1, 1'b1);
    drv(2, 0, 1, 0, 0, 0, 3'b011, 3'b000, 2'd1, 1'b1);
    drv(1, 1, 1, 0, 1, 1, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(3, 0, 1, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(1, 0, 1, 0, 0, 0, 3'b001, 3'b000, 2'd1, 1'b1);
    drv(3, 0, 0, 0, 0, 0, 3'b001, 3'b000, 2'd1, 1'b1);

    // Short left pulse away from a tick is ignored.
    do_reset(6);
    drv(1, 0, 1, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);
    drv(8, 0, 0, 0, 0, 0, 3'b000, 3'b000, 2'd0, 1'b0);

    repeat (2) @(posedge clk);
    #3;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lamp_sequencer.md
LAMP_SEQUENCER -- requirements
Module: lamp_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per sequence step; legal range 2..65535.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 turn_left  input  1  level request for a left sweep.
REQ-005 turn_right  input  1  level request for a right sweep.
REQ-006 emergency  input  1  level request for hazard flashing.
REQ-007 brake  input  1  level brake request.
REQ-008 left_lamp  output  3  left lamps, bit0 innermost.
REQ-009 right_lamp  output  3  right lamps, bit0 innermost.
REQ-010 mode  output  2  active sequence: 0 idle, 1 left, 2 right, 3 hazard.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The prescaler SHALL free-run 0..TICK_DIV-1 and wrap to 0; tick SHALL be high when count = TICK_DIV-1.
REQ-013 The FSM SHALL have states IDLE, L1, L2, L3, R1, R2, R3 and HAZ, and SHALL change state only on a tick cycle.
REQ-014 IDLE on tick SHALL go: to HAZ if emergency=1 or turn_left=turn_right=1; else to L1 if turn_left=1; else to R1 if turn_right=1; else stay in IDLE.
REQ-015 L1->L2->L3->IDLE and R1->R2->R3->IDLE on successive ticks; releasing a turn input mid-sweep SHALL NOT abort the sweep.
REQ-016 emergency=1 on a tick in any L or R state SHALL transition to HAZ (preemption) instead of the normal successor.
REQ-017 HAZ SHALL go to IDLE on every tick, so hazard alternates on/dark at one tick each while held.
REQ-018 A turn request held continuously SHALL repeat the sweep with one dark IDLE tick between sweeps.
REQ-019 Active-side lamps: L1/R1=001, L2/R2=011, L3/R3=111; HAZ drives both sides 111.
REQ-020 brake SHALL be registered once (brake_q); any side not driven by the active sweep SHALL show 111 if brake_q=1, else 000.
REQ-021 Outputs SHALL be decoded from registered state and brake_q only, with no combinational path from any input to any output.
REQ-022 mode SHALL be 1 in L1-L3, 2 in R1-R3, 3 in HAZ and 0 in IDLE.
REQ-023 A brake change SHALL appear at the lamps exactly one cycle later, independent of tick.

Reset
REQ-024 rst=1 at a clock edge SHALL force state IDLE, prescaler 0 and brake_q 0, overriding every other input.
REQ-025 During and after reset, outputs SHALL be left_lamp=000, right_lamp=000, mode=0 and busy=0.
REQ-026 Reset asserted mid-sweep or mid-hazard SHALL abort the sequence immediately at that edge.
REQ-027 The first tick after reset release SHALL occur TICK_DIV cycles after the last reset edge.

Structure
REQ-028 Shared package lamp_pkg SHALL hold the state enumeration, the mode encodings and the lamp pattern constants 000/001/011/111.
REQ-029 The prescaler SHALL be a separate sub-module lamp_prescaler (parameter TICK_DIV; ports clk, rst, tick).
REQ-030 The FSM and output decode SHALL reside in lamp_sequencer.

Verification (TICK_DIV=4; reset released after edge 0; ticks at cycles 4, 8, 12 ...)
REQ-031 Hold turn_left=1 -> left_lamp 001 from cycle 5, 011 from 9, 111 from 13, 000 from 17, 001 from 21; right_lamp=000 and mode=1 throughout the sweep.
REQ-032 Set turn_left=turn_right=1 -> both sides 111 and mode=3 from cycle 5, both 000 from 9, 111 from 13.
REQ-033 turn_right sweep reaching R2, then emergency=1 pulsed across the next tick -> both sides 111 on the cycle after that tick, then IDLE.
REQ-034 brake=1 while idle -> both sides 111 one cycle later; during a left sweep -> right_lamp=111 while left follows 001/011/111.
REQ-035 rst=1 for one cycle during L2 -> next cycle all outputs 0 and busy=0; the next tick occurs 4 cycles later.
REQ-036 turn_left pulsed for one cycle not covering a tick -> no state change; all lamps stay 000.
